// File: rtl/ss2_pkg.sv
// Shared SimpleSerial2 definitions: receiver state encoding, UART defaults (8N1 at
// 32 clocks per bit) and a 2-of-3 majority helper used when SS2_RX_MAJORITY_EN is set.
package ss2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } ss2_rx_state_e;

  localparam int SS2_BIT_RATE   = 32;
  localparam int SS2_DATA_BITS  = 8;
  localparam int SS2_PARITY_EN  = 0;
  localparam int SS2_PARITY_ODD = 0;

  function automatic logic ss2_majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/ss2_rx_sync.sv
// Two-flop synchronizer for the asynchronous rxd line; both flops reset to the
// idle-high level so reset never looks like a start bit.
module ss2_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

  assign dout = s2_q;

endmodule

// File: rtl/ss2_uart_rx.sv
// UART receiver with valid/ready output, frame/parity/overrun pulses.
// Optional macro SS2_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point.
module ss2_uart_rx
  import ss2_pkg::*;
#(
  parameter int pBIT_RATE       = SS2_BIT_RATE,
  parameter int pDATA_BITS      = SS2_DATA_BITS,
  parameter int pPARITY_ENABLED = SS2_PARITY_EN,
  parameter int pPARITY_ODD     = SS2_PARITY_ODD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_error,
  output logic       parity_error,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(pBIT_RATE + 2) + 1;

`ifdef SS2_RX_MAJORITY_EN
  localparam int MAJ_DLY = 1;
`else
  localparam int MAJ_DLY = 0;
`endif

  localparam logic [CNT_W-1:0] START_T  = CNT_W'(pBIT_RATE / 2 + MAJ_DLY);
  localparam logic [CNT_W-1:0] BIT_T    = CNT_W'(pBIT_RATE);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT = 3'(pDATA_BITS - 1);
  localparam logic             PAR_EN   = (pPARITY_ENABLED != 0);
  localparam logic             PAR_ODD  = (pPARITY_ODD != 0);

  logic rxd_s;
  logic sbit;

  ss2_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (rxd),
    .dout  (rxd_s)
  );

`ifdef SS2_RX_MAJORITY_EN
  // Decision is taken one cycle late so the +1 sample is already available.
  logic h1_q, h2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h1_q <= 1'b1;
      h2_q <= 1'b1;
    end else begin
      h1_q <= rxd_s;
      h2_q <= h1_q;
    end
  end

  assign sbit = ss2_majority3(rxd_s, h1_q, h2_q);
`else
  assign sbit = rxd_s;
`endif

  ss2_rx_state_e          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [pDATA_BITS-1:0]  shreg_q, shreg_d;
  logic                   par_acc_q, par_acc_d;
  logic                   par_err_q, par_err_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_error_q, frame_error_d;
  logic                   parity_error_q, parity_error_d;
  logic                   overrun_q, overrun_d;
  logic                   busy_q, busy_d;
  logic [1:0]             prime_q, prime_d;
  logic                   sync_live;
  logic                   sample_now;
  logic [7:0]             data_ext;

  // The synchronizer still holds its reset value for two cycles after release;
  // WAIT_HIGH must not trust it until real line data has propagated through.
  assign sync_live = prime_q[1];
  assign prime_d   = sync_live ? prime_q : prime_q + 2'd1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + ONE;
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    par_acc_d      = par_acc_q;
    par_err_d      = par_err_q;
    data_d         = data_q;
    valid_d        = valid_q;
    frame_error_d  = 1'b0;
    parity_error_d = 1'b0;
    overrun_d      = 1'b0;
    data_ext       = '0;
    data_ext[pDATA_BITS-1:0] = shreg_q;

    sample_now = (state_q == ST_START) ? (cnt_q == START_T) : (cnt_q == BIT_T);
    if (sample_now) cnt_d = ONE;

    if (valid_q && ready) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = ONE;
        if (!rxd_s) state_d = ST_START;
      end
      ST_START: begin
        if (sample_now) begin
          if (sbit) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            par_acc_d = 1'b0;
            par_err_d = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (sample_now) begin
          shreg_d   = {sbit, shreg_q[pDATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ sbit;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (sample_now) begin
          par_err_d = ((par_acc_q ^ sbit) != PAR_ODD);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample_now) begin
          parity_error_d = par_err_q;
          if (sbit) begin
            state_d = ST_IDLE;
            // A same-cycle handshake frees the holding register for the new byte.
            if (valid_q && !ready) begin
              overrun_d = 1'b1;
            end else begin
              data_d  = data_ext;
              valid_d = 1'b1;
            end
          end else begin
            frame_error_d = 1'b1;
            state_d       = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (sync_live && rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_WAIT_HIGH;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_WAIT_HIGH;
      cnt_q          <= '0;
      bit_cnt_q      <= '0;
      par_acc_q      <= 1'b0;
      par_err_q      <= 1'b0;
      data_q         <= 8'h00;
      valid_q        <= 1'b0;
      frame_error_q  <= 1'b0;
      parity_error_q <= 1'b0;
      overrun_q      <= 1'b0;
      busy_q         <= 1'b0;
      prime_q        <= 2'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      par_acc_q      <= par_acc_d;
      par_err_q      <= par_err_d;
      data_q         <= data_d;
      valid_q        <= valid_d;
      frame_error_q  <= frame_error_d;
      parity_error_q <= parity_error_d;
      overrun_q      <= overrun_d;
      busy_q         <= busy_d;
      prime_q        <= prime_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign data         = data_q;
  assign valid        = valid_q;
  assign frame_error  = frame_error_q;
  assign parity_error = parity_error_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ss2_uart_rx.sv
// Scoreboard bench for ss2_uart_rx: default 8N1 instance plus an even-parity instance.
module tb_ss2_uart_rx;

  localparam int BR     = 32;
  localparam int K_BYTE = 0;
  localparam int K_FE   = 1;
  localparam int K_OV   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, frame_error, parity_error, overrun, busy;

  logic       rxd_p = 1'b1;
  logic       ready_p = 1'b1;
  logic [7:0] data_p;
  logic       valid_p, fe_p, pe_p, ov_p, busy_p;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         kind;
    logic [7:0] d;
  } ev_t;
  ev_t expq[$];

  int         pe_cnt_p = 0;
  int         vcnt_p = 0;
  int         other_p = 0;
  logic [7:0] last_p = 8'h00;

  always #5 clk = ~clk;

  ss2_uart_rx dut (
    .clk(clk), .reset(reset), .rxd(rxd), .data(data), .valid(valid), .ready(ready),
    .frame_error(frame_error), .parity_error(parity_error), .overrun(overrun), .busy(busy)
  );

  ss2_uart_rx #(.pBIT_RATE(BR), .pDATA_BITS(8), .pPARITY_ENABLED(1), .pPARITY_ODD(0)) dut_p (
    .clk(clk), .reset(reset), .rxd(rxd_p), .data(data_p), .valid(valid_p), .ready(ready_p),
    .frame_error(fe_p), .parity_error(pe_p), .overrun(ov_p), .busy(busy_p)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void push(int k, logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.d    = d;
    expq.push_back(e);
  endfunction

  function automatic void pop_chk(int k, logic [7:0] d, string nm);
    ev_t e;
    if (expq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: unexpected event kind %0d data %0h, nothing expected", nm, k, d);
    end else begin
      e = expq.pop_front();
      chk({nm, "_kind"}, k, e.kind);
      if (k == K_BYTE && e.kind == K_BYTE) chk(nm, d, e.d);
    end
  endfunction

  // Reference model: what a frame on the line should produce.
  function automatic void expect_frame(logic [7:0] b, logic stop);
    if (stop) push(K_BYTE, b);
    else      push(K_FE, 8'h00);
  endfunction

  function automatic logic even_par_mismatch(logic [7:0] b, logic pbit);
    return ((^b) ^ pbit) != 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_error)    pop_chk(K_FE, 8'h00, "frame_error");
      if (overrun)        pop_chk(K_OV, 8'h00, "overrun");
      if (parity_error)   chk("parity_error_default", 32'd1, 32'd0);
      if (valid && ready) pop_chk(K_BYTE, data, "rx_byte");
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (pe_p) pe_cnt_p++;
      if (fe_p || ov_p) other_p++;
      if (valid_p && ready_p) begin
        last_p = data_p;
        vcnt_p++;
      end
    end
  end

  task automatic drive(input int line, input logic v);
    if (line == 0) rxd = v;
    else           rxd_p = v;
  endtask

  // Leaves the line at the stop-bit level; the caller decides what follows.
  task automatic send_frame(input int line, input logic [7:0] b, input logic use_par,
                            input logic pbit, input logic stop);
    logic bits[12];
    int   n;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    n = 9;
    if (use_par) begin
      bits[n] = pbit;
      n++;
    end
    bits[n] = stop;
    n++;
    for (int i = 0; i < n; i++) begin
      if (i == 0) @(posedge clk);
      else repeat (BR) @(posedge clk);
      #1 drive(line, bits[i]);
    end
    repeat (BR) @(posedge clk);
  endtask

  task automatic idle(input int line, input int cycles);
    #1 drive(line, 1'b1);
    repeat (cycles) @(posedge clk);
  endtask

  initial begin
    logic [7:0] b;
    logic       stop, pb;
    int         exp_pe, exp_v;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fe", frame_error, 0);
    chk("rst_pe", parity_error, 0);
    chk("rst_ov", overrun, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);

    // 0xA5 with exact delivery latency
    expect_frame(8'hA5, 1'b1);
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        @(posedge clk);
        repeat (306) @(posedge clk);
        @(negedge clk) chk("lat_c304_valid", valid, 0);
        @(negedge clk) chk("lat_c305_valid", valid, 1);
        chk("lat_c305_data", data, 8'hA5);
        @(negedge clk) chk("lat_c306_valid", valid, 0);
      end
    join
    idle(0, 20);

    // 10-cycle glitch: false start
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (10) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk) chk("glitch_busy_c16", busy, 1);
    @(posedge clk);
    @(negedge clk) chk("glitch_busy_c17", busy, 0);
    chk("glitch_valid", valid, 0);
    idle(0, 40);

    // bad stop bit, line stuck low for 100 bits, then 0x81
    expect_frame(8'h3C, 1'b0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (100 * BR) @(posedge clk);
    chk("fe_no_valid", valid, 0);
    idle(0, 20);
    expect_frame(8'h81, 1'b1);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    idle(0, 20);
    chk("fe_after_data", data, 8'h81);

    // overrun: 0x11 then 0x22 with ready low
    #1 ready = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    idle(0, 5);
    push(K_OV, 8'h00);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    idle(0, 10);
    chk("ov_keep_data", data, 8'h11);
    chk("ov_keep_valid", valid, 1);
    push(K_BYTE, 8'h11);
    #1 ready = 1'b1;
    repeat (5) @(posedge clk);
    chk("ov_consumed", valid, 0);

    // ready raised exactly on the completion cycle of 0x22
    #1 ready = 1'b0;
    push(K_BYTE, 8'h11);
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    idle(0, 5);
    push(K_BYTE, 8'h22);
    fork
      send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
      begin
        @(posedge clk);
        repeat (306) @(posedge clk);
        #1 ready = 1'b1;
      end
    join
    idle(0, 10);
    chk("swap_data", data, 8'h22);
    chk("swap_valid", valid, 0);

    // even parity instance
    exp_pe = 0;
    exp_v  = 0;
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    if (even_par_mismatch(8'h07, 1'b0)) exp_pe++;
    exp_v++;
    idle(1, 10);
    chk("par_err_cnt", pe_cnt_p, exp_pe);
    chk("par_data", last_p, 8'h07);
    chk("par_vcnt", vcnt_p, exp_v);
    for (int i = 0; i < 5; i++) begin
      b  = 8'($urandom);
      pb = 1'($urandom);
      if (even_par_mismatch(b, pb)) exp_pe++;
      exp_v++;
      send_frame(1, b, 1'b1, pb, 1'b1);
      idle(1, 10);
      chk("par_rand_data", last_p, b);
    end
    chk("par_rand_err_cnt", pe_cnt_p, exp_pe);
    chk("par_rand_vcnt", vcnt_p, exp_v);
    chk("par_other_pulses", other_p, 0);

    // randomized frames on the default instance
    for (int i = 0; i < 20; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      expect_frame(b, stop);
      send_frame(0, b, 1'b0, 1'b0, stop);
      idle(0, $urandom_range(2, 40));
    end

    // reset in the middle of a frame, line low at release
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (152) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", valid, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (400) @(posedge clk);
    chk("midrst_low_valid", valid, 0);
    idle(0, 50);
    expect_frame(8'h5A, 1'b1);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    idle(0, 20);
    chk("midrst_data", data, 8'h5A);

    for (int i = 0; i < 2000 && expq.size() != 0; i++) @(posedge clk);
    chk("queue_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ss2_uart_rx.md
SS2_UART_RX -- requirements
Module: ss2_uart_rx

Interface
REQ-001 The module SHALL have parameter pBIT_RATE, default 32, meaning clocks per UART bit (minimum 4).
REQ-002 The module SHALL have parameter pDATA_BITS, default 8, meaning data bits per frame (5..8).
REQ-003 The module SHALL have parameter pPARITY_ENABLED, default 0, meaning that 1 adds one parity bit after the data bits.
REQ-004 The module SHALL have parameter pPARITY_ODD, default 0, meaning 0 selects even parity and 1 selects odd parity.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The module SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-008 The module SHALL have port data, output, 8 bits: received byte, LSB first on the line, with unused upper bits set to 0.
REQ-009 The module SHALL have port valid, output, 1 bit: data holds an unconsumed byte.
REQ-010 The module SHALL have port ready, input, 1 bit: the consumer accepts data in any cycle where valid and ready are both high.
REQ-011 The module SHALL have port frame_error, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-012 The module SHALL have port parity_error, output, 1 bit: one-cycle pulse on a parity mismatch.
REQ-013 The module SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed byte is dropped.
REQ-014 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 rxd SHALL pass through a 2-flop synchronizer; all timing below is counted from the first cycle the synchronized rxd is low (cycle 0).
REQ-016 The state machine SHALL have the states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-017 IDLE -> START SHALL occur when the synchronized rxd is low.
REQ-018 START SHALL sample at cycle pBIT_RATE/2; a high sample is a false start and returns to IDLE with no error pulse.
REQ-019 Data bit i SHALL be sampled at cycle pBIT_RATE/2 + (i+1)*pBIT_RATE.
REQ-020 The parity bit, when enabled, SHALL be sampled one pBIT_RATE after the last data bit, and the stop bit one pBIT_RATE after that.
REQ-021 A good stop bit SHALL set valid with the new data in the cycle after the stop sample; with defaults this is cycle 305.
REQ-022 A low stop bit SHALL pulse frame_error, discard the byte and enter WAIT_HIGH; WAIT_HIGH -> IDLE occurs when rxd is high.
REQ-023 A parity mismatch SHALL pulse parity_error in the cycle after the stop sample; the byte SHALL still be delivered if the stop bit is good.
REQ-024 valid and data SHALL hold stable until a valid&&ready handshake; valid SHALL clear in the following cycle.
REQ-025 If a byte completes while valid=1 and ready=0, the module SHALL pulse overrun, drop the new byte and keep the old byte.
REQ-026 If a byte completes in the same cycle as a valid&&ready handshake, the module SHALL load the new byte with no overrun.
REQ-027 Reception of the next frame SHALL proceed regardless of the state of valid.

Reset
REQ-028 Reset SHALL clear valid, frame_error, parity_error, overrun and busy to 0, data to 0x00, and both synchronizer flops to 1.
REQ-029 Reset SHALL place the state machine in WAIT_HIGH, so that a line held low at reset release is never decoded as a start bit.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no error pulse and no valid.

Configuration
REQ-031 With macro SS2_RX_MAJORITY_EN defined, each sample point SHALL use a 2-of-3 majority of the synchronized rxd at offsets -1, 0 and +1 cycles around the sample cycle, and every decision SHALL shift one cycle later.
REQ-032 Without SS2_RX_MAJORITY_EN, each sample point SHALL use a single sample at the exact cycle.

Structure
REQ-033 The state encoding and the shared UART parameter defaults (pBIT_RATE=32, 8N1) SHALL live in the shared package ss2_pkg, which is also used by the existing SimpleSerial2 logic.
REQ-034 The synchronizer SHALL be the single sub-module ss2_rx_sync (2 flops, reset value 1); the bit counter and sample counter SHALL live in ss2_uart_rx.

Verification
REQ-035 A frame 0xA5 at 8N1 with ready=1 SHALL produce data=0xA5 with valid for 1 cycle at cycle 305 and no error pulses.
REQ-036 A 10-cycle low glitch on rxd SHALL leave valid=0, produce no error pulse, and leave busy low again by cycle 17.
REQ-037 Frame 0x3C sent with the stop bit low, followed by rxd held low for 100 bits, SHALL pulse frame_error once, leave valid=0, and be followed by a correct decode of a subsequent 0x81.
REQ-038 Frames 0x11 then 0x22 sent with ready=0 SHALL pulse overrun once and keep data=0x11; with ready raised on the 0x22 completion cycle, data SHALL become 0x22 with no overrun.
REQ-039 With pPARITY_ENABLED=1 and pPARITY_ODD=0, frame 0x07 with parity bit 0 SHALL pulse parity_error and deliver 0x07.
REQ-040 Reset asserted at cycle 150 of a frame, with rxd low at release, SHALL give no valid until rxd has been high and a new frame 0x5A is received, which SHALL decode as 0x5A.
